audio_nios_pio_in_irq: RTL

Parametrised Avalon-MM input PIO. Generalises the single-bit read-only input port to WIDTH bits and adds input synchronisation, per-bit edge capture, an interrupt mask and an IRQ output. Sits between board-level status pins (SD write-protect, card-detect, buttons) and the Nios II data master.

---
 rtl/audio_nios_pio_in_irq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/audio_nios_pio_in_irq.sv
`default_nettype none
// ============================================================================
//  Module   : audio_nios_pio_in_irq
//  Purpose  : Avalon-MM input PIO with per-bit synchroniser, edge capture,
//             interrupt mask and registered IRQ output.
//  Options  : define PIO_IN_DEBOUNCE_EN to insert a per-bit debounce filter
//             between the synchroniser and the edge detector.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_nios_pio_in_irq #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_TYPE        = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // Synchroniser chain; index SYNC_STAGES-1 is the settled value.
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] clear_bits;
    logic [31:0]      rd_mux;
    logic             wr_stb;
    logic             irq_src;
    logic             unused_writedata;

    // Bits of writedata above WIDTH carry no meaning for this block.
    assign unused_writedata = ^writedata;

    // Shift the raw inputs through the synchroniser flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] db_cnt [WIDTH];
    logic [WIDTH-1:0] db_val;

    // Count consecutive cycles the synchronised bit disagrees with the
    // filtered bit; accept the new level only after a full stable run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_val <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                db_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < WIDTH; b++) begin
                if (sync_last[b] == db_val[b]) begin
                    db_cnt[b] <= '0;
                end else if (db_cnt[b] == CNT_MAX) begin
                    db_val[b] <= sync_last[b];
                    db_cnt[b] <= '0;
                end else begin
                    db_cnt[b] <= db_cnt[b] + 1'b1;
                end
            end
        end
    end

    assign data_in = db_val;
`else
    assign data_in = sync_last;
`endif

    // Remember last cycle's input to detect transitions.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= data_in;
        end
    end

    assign rise = data_in & ~prev;
    assign fall = ~data_in & prev;

    // Select which transition polarity is recorded.
    always_comb begin
        edge_det = rise | fall;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
    end

    assign wr_stb     = chipselect & ~write_n;
    assign clear_bits = (wr_stb && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // Mask register and write-1-to-clear capture; a new edge beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask     <= '0;
            edge_capture <= '0;
        end else begin
            if (wr_stb && address == 2'd2) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_capture <= edge_det | (edge_capture & ~clear_bits);
        end
    end

    // Read-side register map; unused upper bits stay zero.
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(data_in);
            2'd2:    rd_mux = 32'(irq_mask);
            2'd3:    rd_mux = 32'(edge_capture);
            default: rd_mux = '0;
        endcase
    end

    assign irq_src = (IRQ_TYPE == 1) ? |(edge_capture & irq_mask)
                                     : |(data_in & irq_mask);

    // Register read data and the interrupt request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_mux;
            irq      <= irq_src;
        end
    end

endmodule
`default_nettype wire
